// File: rtl/eeg_p300_pkg.sv
// Shared encodings and default levels for the P300 pattern generator, the detector and their benches.
package eeg_p300_pkg;

  typedef enum logic [1:0] {
    MODE_VALID  = 2'd0,
    MODE_LATE   = 2'd1,
    MODE_SUBTHR = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_RISE   = 3'd1,
    PH_PEAK   = 3'd2,
    PH_FALL   = 3'd3,
    PH_RETURN = 3'd4
  } phase_t;

  localparam logic [7:0] DEF_BASELINE    = 8'd50;
  localparam logic [7:0] DEF_RISE_LVL    = 8'd55;
  localparam logic [7:0] DEF_PEAK_LVL    = 8'd75;
  localparam logic [7:0] DEF_SUBPEAK_LVL = 8'd60;
  localparam logic [7:0] DEF_FALL_LVL    = 8'd59;

  // The reserved encoding behaves as VALID.
  function automatic mode_t norm_mode(input logic [1:0] m);
    if (m == MODE_LATE)   return MODE_LATE;
    if (m == MODE_SUBTHR) return MODE_SUBTHR;
    return MODE_VALID;
  endfunction

endpackage

// File: rtl/eeg_phase_timer.sv
// Loadable down-counter timing one waveform phase; expired reads high while the count is zero.
module eeg_phase_timer #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] load_val,
  input  logic             load,
  input  logic             dec,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/eeg_p300_pattern_gen.sv
// Synthetic EEG source: steps through rise/peak/fall/return levels per trial to stimulate the P300 detector.
module eeg_p300_pattern_gen
  import eeg_p300_pkg::*;
#(
  parameter logic [7:0]  BASELINE    = DEF_BASELINE,
  parameter logic [7:0]  RISE_LVL    = DEF_RISE_LVL,
  parameter logic [7:0]  PEAK_LVL    = DEF_PEAK_LVL,
  parameter logic [7:0]  SUBPEAK_LVL = DEF_SUBPEAK_LVL,
  parameter logic [7:0]  FALL_LVL    = DEF_FALL_LVL,
  parameter int unsigned PHASE_CYC   = 10,
  parameter int unsigned LATE_CYC    = 275,
  parameter int unsigned CNT_W       = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [3:0] num_trials,
  input  logic       abort,
  output logic [7:0] eeg_signal,
  output logic [2:0] phase_id,
  output logic       busy,
  output logic       done
);

  phase_t           state, nxt;
  mode_t            mode_q, mode_eff;
  logic [3:0]       trials_q;
  logic             accept, last_trial, finish, next_trial;
  logic             timer_load, timer_dec, expired;
  logic [CNT_W-1:0] load_val;
  logic [7:0]       level_nxt;

  eeg_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_val (load_val),
    .load     (timer_load),
    .dec      (timer_dec),
    .expired  (expired)
  );

  always_comb begin
    accept     = (state == PH_IDLE) && start && !abort;
    // In IDLE the incoming mode selects the first RISE length; afterwards the latched copy rules.
    mode_eff   = (state == PH_IDLE) ? norm_mode(mode) : mode_q;
    last_trial = (trials_q == 4'd1);
    nxt        = state;
    finish     = 1'b0;
    next_trial = 1'b0;
    case (state)
      PH_IDLE:   if (accept) nxt = PH_RISE;
      PH_RISE:   if (expired) nxt = PH_PEAK;
      PH_PEAK:   if (expired) nxt = (mode_q == MODE_SUBTHR) ? PH_RETURN : PH_FALL;
      PH_FALL:   if (expired) nxt = PH_RETURN;
      PH_RETURN: begin
        if (expired) begin
          nxt        = last_trial ? PH_IDLE : PH_RISE;
          finish     = last_trial;
          next_trial = !last_trial;
        end
      end
      default:   nxt = PH_IDLE;
    endcase
    if (abort && (state != PH_IDLE)) begin
      nxt        = PH_IDLE;
      finish     = 1'b0;
      next_trial = 1'b0;
    end

    timer_load = (nxt != state) && (nxt != PH_IDLE);
    timer_dec  = (state != PH_IDLE);
    load_val   = ((nxt == PH_RISE) && (mode_eff == MODE_LATE)) ? CNT_W'(LATE_CYC - 1)
                                                               : CNT_W'(PHASE_CYC - 1);

    level_nxt = BASELINE;
    case (nxt)
      PH_RISE: level_nxt = RISE_LVL;
      PH_PEAK: level_nxt = (mode_eff == MODE_SUBTHR) ? SUBPEAK_LVL : PEAK_LVL;
      PH_FALL: level_nxt = FALL_LVL;
      default: level_nxt = BASELINE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PH_IDLE;
      eeg_signal <= BASELINE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mode_q     <= MODE_VALID;
      trials_q   <= '0;
    end else begin
      state      <= nxt;
      eeg_signal <= level_nxt;
      busy       <= (nxt != PH_IDLE);
      done       <= finish;
      if (accept) begin
        mode_q   <= mode_eff;
        trials_q <= (num_trials == 4'd0) ? 4'd1 : num_trials;
      end else if (next_trial) begin
        trials_q <= trials_q - 4'd1;
      end
    end
  end

  assign phase_id = state;

endmodule

// File: tb/tb_eeg_p300_pattern_gen.sv
// Bench for eeg_p300_pattern_gen: table-driven runs, random runs and abort/reset corner sequences.
module tb_eeg_p300_pattern_gen;
  import eeg_p300_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [1:0] mode;
  logic [3:0] num_trials;
  logic [7:0] eeg_signal;
  logic [2:0] phase_id;
  logic       busy, done;

  int errors = 0;
  int checks = 0;

  eeg_p300_pattern_gen dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .num_trials (num_trials),
    .abort      (abort),
    .eeg_signal (eeg_signal),
    .phase_id   (phase_id),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] lvl;
    logic [2:0] ph;
  } samp_t;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] trials;
    int         start_at;
    int         abort_at;
    int         exp_busy;
  } vec_t;

  samp_t exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push_n(input int n, input logic [7:0] lvl, input phase_t ph);
    samp_t s;
    s.lvl = lvl;
    s.ph  = ph;
    for (int i = 0; i < n; i++) exp_q.push_back(s);
  endtask

  // Expected sample stream for one run, built directly from the waveform description.
  task automatic build(input logic [1:0] m, input logic [3:0] n);
    int trials;
    trials = (n == 0) ? 1 : int'(n);
    exp_q.delete();
    for (int t = 0; t < trials; t++) begin
      push_n((m == 2'd1) ? 275 : 10, 8'd55, PH_RISE);
      push_n(10, (m == 2'd2) ? 8'd60 : 8'd75, PH_PEAK);
      if (m != 2'd2) push_n(10, 8'd59, PH_FALL);
      push_n(10, 8'd50, PH_RETURN);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int busy_cnt, dones;
    bit aborted;
    busy_cnt = 0;
    dones    = 0;
    aborted  = 1'b0;
    build(v.mode, v.trials);
    mode       = v.mode;
    num_trials = v.trials;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    mode       = 2'($urandom);
    num_trials = 4'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      check("sample", int'(eeg_signal), int'(exp_q[i].lvl));
      check("phase_id", int'(phase_id), int'(exp_q[i].ph));
      if (busy) busy_cnt++;
      if (done) dones++;
      if (i == v.start_at) begin
        start      = 1'b1;
        mode       = 2'd1;
        num_trials = 4'd7;
      end
      abort = (i == v.abort_at);
      tick();
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        aborted = 1'b1;
        check("abort_sample", int'(eeg_signal), 50);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_phase", int'(phase_id), int'(PH_IDLE));
        break;
      end
    end
    if (!aborted) begin
      check("end_done", int'(done), 1);
      check("end_busy", int'(busy), 0);
      check("end_sample", int'(eeg_signal), 50);
      check("end_phase", int'(phase_id), int'(PH_IDLE));
      tick();
      check("done_pulse_width", int'(done), 0);
    end
    check("busy_cycles", busy_cnt, v.exp_busy);
    check("done_during_run", dones, 0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{2'd0, 4'd1, -1, -1, 40};
    vecs[1] = '{2'd1, 4'd1, -1, -1, 305};
    vecs[2] = '{2'd2, 4'd1, -1, -1, 30};
    vecs[3] = '{2'd0, 4'd3, -1, -1, 120};
    vecs[4] = '{2'd0, 4'd0, -1, -1, 40};
    vecs[5] = '{2'd3, 4'd1, -1, -1, 40};
    vecs[6] = '{2'd0, 4'd1, 12, -1, 40};
    vecs[7] = '{2'd0, 4'd1, -1, 15, 16};
    vecs[8] = '{2'd2, 4'd2, 25, -1, 60};

    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; num_trials = 4'd1;
    repeat (3) tick();
    check("reset_sample", int'(eeg_signal), 50);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_phase", int'(phase_id), int'(PH_IDLE));
    reset = 1'b0;
    tick();

    foreach (vecs[k]) begin
      run_vec(vecs[k]);
      tick();
    end

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; mode = 2'd0; num_trials = 4'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", int'(busy), 0);
    check("start_abort_phase", int'(phase_id), int'(PH_IDLE));
    tick();
    check("start_abort_stay", int'(busy), 0);

    // abort in IDLE has no effect
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_sample", int'(eeg_signal), 50);
    check("idle_abort_done", int'(done), 0);

    // reset at cycle 20 of a LATE run, then a clean run
    mode = 2'd1; num_trials = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("late_mid_sample", int'(eeg_signal), 55);
    reset = 1'b1;
    tick();
    check("midreset_sample", int'(eeg_signal), 50);
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    reset = 1'b0;
    tick();
    run_vec(vecs[0]);

    // randomized runs against the stream model and the run-length formula
    for (int r = 0; r < 8; r++) begin
      vec_t v;
      int per, eff;
      v.mode     = 2'($urandom_range(0, 3));
      v.trials   = 4'($urandom_range(0, 3));
      v.start_at = (r % 2 == 1) ? int'($urandom_range(0, 29)) : -1;
      v.abort_at = -1;
      per = (v.mode == 2'd1) ? 305 : (v.mode == 2'd2) ? 30 : 40;
      eff = (v.trials == 0) ? 1 : int'(v.trials);
      v.exp_busy = per * eff;
      run_vec(v);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
